fb_selector_pq: RTL

- Parametrised successor to the gen/fb output selector of the DRSSTC controller.
- Drives the startup generator to the gate driver, then qualifies the resonant feedback signal by measuring its period before handing the output over to it.
- Monitors feedback period and presence while it is selected. On loss or an out-of-window period, falls back to the generator and holds off before requalifying.
- Sits between the interrupter-gated generator and the gate-drive output stage.

---
 rtl/fb_selector_pq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fb_selector_pq.sv
// Gen/fb drive selector: runs the startup generator, qualifies the feedback period, then hands over to fb.
// Define FALLBACK_CNT_EN to add a saturating fault counter (fault_cnt) with synchronous clear (fault_cnt_clr).
module fb_selector_pq #(
    parameter int unsigned CLK_MHZ           = 100,
    parameter int unsigned PERIODS_TO_SWITCH = 4,
    parameter int unsigned RESET_TIMEOUT_US  = 4,
    parameter int unsigned FB_MIN_PER_CLK    = 100,
    parameter int unsigned FB_MAX_PER_CLK    = 2000,
    parameter int unsigned LOCK_PERIODS      = 2,
    parameter int unsigned HOLDOFF_PERIODS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gen,
    input  logic       fb,
`ifdef FALLBACK_CNT_EN
    input  logic       fault_cnt_clr,
    output logic [7:0] fault_cnt,
`endif
    output logic       out,
    output logic       locked,
    output logic       fault
);
    localparam int unsigned TIMEOUT_CNT = CLK_MHZ * RESET_TIMEOUT_US;
    localparam int unsigned PER_SAT     = FB_MAX_PER_CLK + 1;
    localparam int unsigned GEN_MAX     = (PERIODS_TO_SWITCH > HOLDOFF_PERIODS) ?
                                          PERIODS_TO_SWITCH : HOLDOFF_PERIODS;
    localparam int unsigned GW = $clog2(GEN_MAX + 1);
    localparam int unsigned LW = $clog2(LOCK_PERIODS + 1);
    localparam int unsigned PW = $clog2(PER_SAT + 1);
    localparam int unsigned TW = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;

    localparam logic [GW-1:0] GEN_SWITCH  = GW'(PERIODS_TO_SWITCH);
    localparam logic [GW-1:0] GEN_HOLDOFF = GW'(HOLDOFF_PERIODS);
    localparam logic [GW-1:0] GEN_ONE     = GW'(1);
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_PERIODS - 1);
    localparam logic [PW-1:0] PER_SAT_V   = PW'(PER_SAT);
    localparam logic [PW-1:0] PER_LO      = PW'(FB_MIN_PER_CLK - 1);
    localparam logic [PW-1:0] PER_HI      = PW'(FB_MAX_PER_CLK - 1);
    localparam logic [TW-1:0] TMO_RELOAD  = TW'(TIMEOUT_CNT - 1);

    typedef enum logic [1:0] {GEN_RUN, QUALIFY, FB_RUN, HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gen_cnt_q, gen_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          per_valid_q, per_valid_d;
    logic          fault_pend_q, fault_pend_d;
    logic          locked_q, locked_d;
    logic          fault_q, fault_d;
    logic          gen_prev_q, fb_prev_q;

    logic gen_fall, fb_fall, per_sat, in_win;

    assign gen_fall = gen_prev_q & ~gen;
    assign fb_fall  = fb_prev_q & ~fb;
    assign per_sat  = (per_cnt_q == PER_SAT_V);
    // Measured period is per_cnt+1, so the window bounds are shifted down by one.
    assign in_win   = (per_cnt_q >= PER_LO) && (per_cnt_q <= PER_HI);

    always_comb begin
        state_d      = state_q;
        gen_cnt_d    = gen_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        per_valid_d  = per_valid_q;
        per_cnt_d    = '0;
        tmo_cnt_d    = tmo_cnt_q;
        fault_pend_d = fault_pend_q;
        fault_d      = 1'b0;
        case (state_q)
            GEN_RUN, HOLDOFF: begin
                if (gen_fall) begin
                    if (gen_cnt_q == GEN_ONE) begin
                        state_d     = QUALIFY;
                        lock_cnt_d  = '0;
                        per_valid_d = 1'b0;
                    end else begin
                        gen_cnt_d = gen_cnt_q - GW'(1);
                    end
                end
            end
            QUALIFY: begin
                per_cnt_d = per_sat ? per_cnt_q : per_cnt_q + PW'(1);
                if (fb_fall) begin
                    per_cnt_d = '0;
                    if (!per_valid_q) begin
                        per_valid_d = 1'b1;
                    end else if (in_win) begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                        if (lock_cnt_q == LOCK_LAST) state_d = FB_RUN;
                    end else begin
                        lock_cnt_d  = '0;
                        per_valid_d = 1'b0;
                    end
                end else if (per_valid_q && per_sat) begin
                    lock_cnt_d  = '0;
                    per_valid_d = 1'b0;
                end
            end
            FB_RUN: begin
                per_cnt_d = per_sat ? per_cnt_q : per_cnt_q + PW'(1);
                if (fb_fall) begin
                    per_cnt_d = '0;
                    if (!in_win) fault_pend_d = 1'b1;
                end else if (per_sat) begin
                    fault_pend_d = 1'b1;
                end
                if (fb)                     tmo_cnt_d = TMO_RELOAD;
                else if (tmo_cnt_q != '0)   tmo_cnt_d = tmo_cnt_q - TW'(1);
                // Falling back is deferred until gen is low so the bridge never sees a cut pulse.
                if ((tmo_cnt_q == '0 || fault_pend_q) && !gen) begin
                    state_d      = HOLDOFF;
                    fault_d      = 1'b1;
                    fault_pend_d = 1'b0;
                    tmo_cnt_d    = TMO_RELOAD;
                    gen_cnt_d    = GEN_HOLDOFF;
                    per_cnt_d    = '0;
                    lock_cnt_d   = '0;
                    per_valid_d  = 1'b0;
                end
            end
            default: state_d = GEN_RUN;
        endcase
        locked_d = (state_d == FB_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GEN_RUN;
            gen_cnt_q    <= GEN_SWITCH;
            lock_cnt_q   <= '0;
            per_valid_q  <= 1'b0;
            per_cnt_q    <= '0;
            tmo_cnt_q    <= TMO_RELOAD;
            fault_pend_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            gen_prev_q   <= 1'b0;
            fb_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gen_cnt_q    <= gen_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            per_valid_q  <= per_valid_d;
            per_cnt_q    <= per_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            fault_pend_q <= fault_pend_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            gen_prev_q   <= gen;
            fb_prev_q    <= fb;
        end
    end

    assign out    = (state_q == FB_RUN) ? fb : gen;
    assign locked = locked_q;
    assign fault  = fault_q;

`ifdef FALLBACK_CNT_EN
    logic [7:0] fault_cnt_q, fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (fault_cnt_clr)                         fault_cnt_d = '0;
        else if (fault_d && fault_cnt_q != '1)     fault_cnt_d = fault_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) fault_cnt_q <= '0;
        else     fault_cnt_q <= fault_cnt_d;
    end

    assign fault_cnt = fault_cnt_q;
`endif
endmodule
